// File: rtl/lx32_mem_pkg.sv
// Shared types and helpers for the LX32 data-memory responder.
// Address checks live here so the core-level memory model can reuse them.
package lx32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned BYTE_W = 8;

  function automatic logic addr_aligned(input logic [1:0] lo_bits);
    return lo_bits == 2'b00;
  endfunction

  // Offset and limit are widened to 64 bits so any WIDTH up to 64 fits.
  function automatic logic offset_in_range(input logic [63:0] offset,
                                           input logic [63:0] limit);
    return offset < limit;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with a synchronous byte-enable write port and a combinational
// read port. Contents are deliberately not reset.
module dmem_array
  import lx32_mem_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [AW-1:0]             i_waddr,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic [WIDTH/BYTE_W-1:0]   i_be,
  input  logic [AW-1:0]             i_raddr,
  output logic [WIDTH-1:0]          o_rdata
);

  localparam int unsigned LANES = WIDTH / BYTE_W;

  logic [WIDTH-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (i_be[b]) begin
          r_mem[i_waddr][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the LX32 LSU interface: one request at a time, a fixed number
// of wait states, then a registered one-cycle response pulse.
module dmem_responder
  import lx32_mem_pkg::*;
#(
  parameter int unsigned     WIDTH       = 32,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter int unsigned     WAIT_STATES = 1,
  parameter logic [WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_req,
  input  logic [WIDTH-1:0]        mem_addr,
  input  logic [WIDTH-1:0]        mem_wdata,
  input  logic                    mem_we,
  input  logic [WIDTH/8-1:0]      mem_be,
  output logic                    mem_ready,
  output logic                    mem_rvalid,
  output logic [WIDTH-1:0]        mem_rdata,
  output logic                    mem_err,
  output logic [1:0]              o_dbg_state
);

  // Handshake: a request transfers on a rising edge where mem_req=1 and
  // mem_ready=1; requests seen while busy are dropped, so the requester must
  // hold mem_req until it samples mem_ready. mem_rvalid is a single-cycle
  // pulse, with mem_rdata/mem_err meaningful only alongside it.

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) * 64'd4;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [WIDTH-1:0]     r_addr;
  logic [WIDTH-1:0]     r_wdata;
  logic                 r_we;
  logic [WIDTH/8-1:0]   r_be;
  logic                 r_rvalid;
  logic [WIDTH-1:0]     r_rdata;
  logic                 r_err;

  logic [WIDTH-1:0]     w_off;
  logic                 w_err;
  logic [AW-1:0]        w_idx;
  logic                 w_commit;
  logic [WIDTH-1:0]     w_rdata;

  assign w_off    = r_addr - BASE_ADDR;
  assign w_err    = !addr_aligned(r_addr[1:0]) || !offset_in_range(64'(w_off), LIMIT);
  assign w_idx    = w_off[AW+1:2];
  // The store lands on the RESP->IDLE edge, so a reset during WAIT/RESP aborts it.
  assign w_commit = (r_state == RESP) && r_we && !w_err;

  dmem_array #(
    .WIDTH       (WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_commit),
    .i_waddr (w_idx),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_we    <= mem_we;
            r_be    <= mem_be;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= RESP;
        end
        RESP: begin
          // Read happens here so it observes every store committed earlier.
          r_rvalid <= 1'b1;
          r_err    <= w_err;
          r_rdata  <= (!r_we && !w_err) ? w_rdata : '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_ready   = (r_state == IDLE);
  assign mem_rvalid  = r_rvalid;
  assign mem_rdata   = r_rdata;
  assign mem_err     = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_STATES 1, 0, 3) against a
// word-map reference model with byte-lane writes and address-rule errors.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0]       req_v, we_v, rdy_v, rvalid_v, err_v;
  logic [2:0][31:0] addr_v, wdata_v, rdata_v;
  logic [2:0][3:0]  be_v;
  logic [2:0][1:0]  dbg_v;

  int ws_tab [3] = '{1, 0, 3};
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic [31:0] ref_mem[int];

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .mem_req(req_v[0]), .mem_addr(addr_v[0]),
    .mem_wdata(wdata_v[0]), .mem_we(we_v[0]), .mem_be(be_v[0]),
    .mem_ready(rdy_v[0]), .mem_rvalid(rvalid_v[0]), .mem_rdata(rdata_v[0]),
    .mem_err(err_v[0]), .o_dbg_state(dbg_v[0]));

  dmem_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .mem_req(req_v[1]), .mem_addr(addr_v[1]),
    .mem_wdata(wdata_v[1]), .mem_we(we_v[1]), .mem_be(be_v[1]),
    .mem_ready(rdy_v[1]), .mem_rvalid(rvalid_v[1]), .mem_rdata(rdata_v[1]),
    .mem_err(err_v[1]), .o_dbg_state(dbg_v[1]));

  dmem_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .mem_req(req_v[2]), .mem_addr(addr_v[2]),
    .mem_wdata(wdata_v[2]), .mem_we(we_v[2]), .mem_be(be_v[2]),
    .mem_ready(rdy_v[2]), .mem_rvalid(rvalid_v[2]), .mem_rdata(rdata_v[2]),
    .mem_err(err_v[2]), .o_dbg_state(dbg_v[2]));

  // Reference: word map keyed per instance; depth 1024 words, base 0.
  function automatic void model(input int d, input bit we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [3:0] be,
                                output logic [31:0] rd, output logic er);
    int key;
    logic [31:0] w;
    er = (addr % 4 != 0) || (addr >= 32'h1000);
    rd = '0;
    if (!er) begin
      key = d * 1024 + int'(addr / 4);
      w = ref_mem.exists(key) ? ref_mem[key] : 'x;
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[key] = w;
      end else begin
        rd = w;
      end
    end
  endfunction

  task automatic do_txn(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int rdy_low);
    int j;
    @(negedge clk);
    req_v[d] = 1'b1; we_v[d] = we; addr_v[d] = addr; wdata_v[d] = wd; be_v[d] = be;
    j = 0;
    while (rdy_v[d] !== 1'b1 && j < 50) begin @(negedge clk); j++; end
    @(posedge clk);
    @(negedge clk);
    req_v[d] = 1'b0;
    lat = -1; rdy_low = 0; rd = '0; er = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rvalid_v[d] === 1'b1) begin
        lat = k; rd = rdata_v[d]; er = err_v[d];
        break;
      end
      if (rdy_v[d] !== 1'b1) rdy_low++;
      @(negedge clk);
    end
  endtask

  task automatic issue(input int d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int rl, output logic [31:0] e, output logic ee);
    model(d, we, addr, wd, be, e, ee);
    do_txn(d, we, addr, wd, be, rd, er, lat, rl);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rdy_v[d] !== 1'b1 || rvalid_v[d] !== 1'b0 || rdata_v[d] !== 32'h0 ||
          err_v[d] !== 1'b0 || dbg_v[d] !== 2'd0) begin
        errors++;
        $display("FAIL reset_values dut%0d: ready=%b rvalid=%b rdata=%h err=%b state=%0d, want 1 0 0 0 0",
                 d, rdy_v[d], rvalid_v[d], rdata_v[d], err_v[d], dbg_v[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [31:0] rd, e; logic er, ee; int lat, rl;
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 16; w++)
        issue(d, 1'b1, 32'(w * 4), $urandom, 4'hF, rd, er, lat, rl, e, ee);
  endtask

  task automatic test_store_load();
    logic [31:0] rd, e; logic er, ee; int lat, rl;
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, rl, e, ee);
    checks++;
    if (lat !== 2 || rl !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL store_timing: lat=%0d ready_low=%0d err=%b rdata=%h, want 2 2 0 0", lat, rl, er, rd);
    end
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rl, e, ee);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2 || rl !== 2) begin
      errors++;
      $display("FAIL load_after_store: rdata=%h err=%b lat=%0d ready_low=%0d, want deadbeef 0 2 2", rd, er, lat, rl);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd, e; logic er, ee; int lat, rl;
    issue(0, 1'b1, 32'hA0, 32'hDEADBEEF, 4'hF, rd, er, lat, rl, e, ee);
    issue(0, 1'b1, 32'hA0, 32'h12345678, 4'b0101, rd, er, lat, rl, e, ee);
    issue(0, 1'b0, 32'hA0, 32'h0, 4'h0, rd, er, lat, rl, e, ee);
    checks++;
    if (rd !== 32'hDE34BE78 || er !== 1'b0) begin
      errors++;
      $display("FAIL byte_enables: rdata=%h err=%b, want de34be78 0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, e; logic er, ee; int lat, rl;
    issue(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat, rl, e, ee);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      errors++;
      $display("FAIL misaligned_load: err=%b rdata=%h lat=%0d, want 1 0 2", er, rd, lat);
    end
    issue(0, 1'b1, 32'h1000, 32'h55AA55AA, 4'hF, rd, er, lat, rl, e, ee);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      errors++;
      $display("FAIL out_of_range_store: err=%b rdata=%h lat=%0d, want 1 0 2", er, rd, lat);
    end
    issue(0, 1'b1, 32'h2, 32'h77777777, 4'hF, rd, er, lat, rl, e, ee);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, rl, e, ee);
    checks++;
    if (rd !== e || er !== 1'b0) begin
      errors++;
      $display("FAIL error_side_effect: rdata=%h err=%b, want %h 0", rd, er, e);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, e; logic er, ee; int lat, rl;
    for (int d = 1; d < 3; d++) begin
      issue(d, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat, rl, e, ee);
      checks++;
      if (lat !== ws_tab[d] + 1 || rl !== ws_tab[d] + 1 || rd !== e || er !== 1'b0) begin
        errors++;
        $display("FAIL wait_states ws=%0d: lat=%0d ready_low=%0d rdata=%h err=%b, want %0d %0d %h 0",
                 ws_tab[d], lat, rl, rd, er, ws_tab[d] + 1, ws_tab[d] + 1, e);
      end
    end
  endtask

  task automatic test_back_to_back(input int d);
    int k, got, last_acc;
    logic [31:0] a, wd, e; logic [3:0] be; bit we; logic ee;
    k = 0; got = 0; last_acc = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rvalid_v[d] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_response dut%0d: rdata=%h, want no response", d, rdata_v[d]);
        end else begin
          e = exp_q.pop_front(); ee = exp_err_q.pop_front();
          if (rdata_v[d] !== e || err_v[d] !== ee) begin
            errors++;
            $display("FAIL b2b_response dut%0d: rdata=%h err=%b, want %h %b", d, rdata_v[d], err_v[d], e, ee);
          end
        end
        got++;
      end
      if (rdy_v[d] === 1'b1 && k < 4) begin
        we = 1'($urandom_range(0, 1));
        a  = 32'($urandom_range(0, 15)) << 2;
        wd = $urandom;
        be = 4'($urandom_range(0, 15));
        req_v[d] = 1'b1; we_v[d] = we; addr_v[d] = a; wdata_v[d] = wd; be_v[d] = be;
        model(d, we, a, wd, be, e, ee);
        exp_q.push_back(e); exp_err_q.push_back(ee);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != ws_tab[d] + 2) begin
            errors++;
            $display("FAIL b2b_spacing dut%0d: %0d cycles, want %0d", d, cyc - last_acc, ws_tab[d] + 2);
          end
        end
        last_acc = cyc;
        k++;
      end else if (rdy_v[d] === 1'b1) begin
        req_v[d] = 1'b0;
      end
      if (k == 4 && got == 4) break;
    end
    req_v[d] = 1'b0;
    repeat (ws_tab[d] + 3) begin
      @(negedge clk);
      if (rvalid_v[d] === 1'b1) got++;
    end
    checks++;
    if (got != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count dut%0d: responses=%0d pending=%0d, want 4 0", d, got, exp_q.size());
    end
    exp_q.delete(); exp_err_q.delete();
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd, e; logic er, ee; int lat, rl, spurious;
    issue(0, 1'b1, 32'h20, 32'h0, 4'hF, rd, er, lat, rl, e, ee);
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'hCAFEF00D; be_v[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_v[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdy_v[0] !== 1'b1 || rvalid_v[0] !== 1'b0 || rdata_v[0] !== 32'h0 ||
        err_v[0] !== 1'b0 || dbg_v[0] !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_op_outputs: ready=%b rvalid=%b rdata=%h err=%b state=%0d, want 1 0 0 0 0",
               rdy_v[0], rvalid_v[0], rdata_v[0], err_v[0], dbg_v[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: ready=%b, want 1", rdy_v[0]);
    end
    // Request asserted together with reset: reset must win.
    @(negedge clk);
    rst_n = 1'b0; req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'hBAD0BAD0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; req_v[0] = 1'b0;
    spurious = 0;
    repeat (5) begin
      @(negedge clk);
      if (rvalid_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL reset_spurious_activity: %0d bad cycles, want 0", spurious);
    end
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, rl, e, ee);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL reset_aborted_store: rdata=%h err=%b, want 00000000 0", rd, er);
    end
  endtask

  task automatic test_be_zero();
    logic [31:0] rd, e; logic er, ee; int lat, rl;
    issue(0, 1'b1, 32'h30, 32'h11111111, 4'hF, rd, er, lat, rl, e, ee);
    issue(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, rd, er, lat, rl, e, ee);
    checks++;
    if (lat !== 2 || er !== 1'b0) begin
      errors++;
      $display("FAIL be_zero_response: lat=%0d err=%b, want 2 0", lat, er);
    end
    issue(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat, rl, e, ee);
    checks++;
    if (rd !== 32'h11111111) begin
      errors++;
      $display("FAIL be_zero_data: rdata=%h, want 11111111", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, e, a; logic er, ee; int lat, rl, d, sel; bit we;
    for (int n = 0; n < 30; n++) begin
      d   = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      a   = 32'($urandom_range(0, 15)) << 2;
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      else if (sel == 1) a = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      we = 1'($urandom_range(0, 1));
      issue(d, we, a, $urandom, 4'($urandom_range(0, 15)), rd, er, lat, rl, e, ee);
      exp_q.push_back(e); exp_err_q.push_back(ee);
      e = exp_q.pop_front(); ee = exp_err_q.pop_front();
      checks++;
      if (rd !== e || er !== ee || lat !== ws_tab[d] + 1) begin
        errors++;
        $display("FAIL random_txn %0d dut%0d addr=%h we=%b: rdata=%h err=%b lat=%0d, want %h %b %0d",
                 n, d, a, we, rd, er, lat, e, ee, ws_tab[d] + 1);
      end
    end
  endtask

  initial begin
    req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0; be_v = '0;
    test_reset();
    test_init();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_wait_states();
    test_back_to_back(0);
    test_back_to_back(2);
    test_reset_mid_op();
    test_be_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
